// File: rtl/ula_operand_issue.sv
// Operand-fetch/issue stage in front of the ULA: register file, operand read
// with writeback bypass, busy-bit scoreboard for RAW/WAW stalls, and a
// registered A/B/opcode output with a valid/ready handshake.
module ula_operand_issue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_we,
    input  logic              in_use_imm,
    input  logic [IMM_W-1:0]  in_imm,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [4:0]        opcode,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_we,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    logic              started;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] b_val;
    logic              haz_rs;
    logic              haz_rt;
    logic              haz_rd;
    logic              hazard;
    logic              accept;

    // Operand read with same-cycle writeback bypass; r0 always reads zero.
    always_comb begin
        rs_val = regs[in_rs];
        rt_val = regs[in_rt];
        if (wb_en && (wb_addr == in_rs)) rs_val = wb_data;
        if (wb_en && (wb_addr == in_rt)) rt_val = wb_data;
        if (in_rs == '0) rs_val = '0;
        if (in_rt == '0) rt_val = '0;
        b_val = in_use_imm ? {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm} : rt_val;
    end

    // Hazard detection; a writeback landing this cycle releases the register.
    always_comb begin
        haz_rs = (in_rs != '0) && busy[in_rs] && !(wb_en && (wb_addr == in_rs));
        haz_rt = (in_rt != '0) && !in_use_imm && busy[in_rt]
                 && !(wb_en && (wb_addr == in_rt));
        haz_rd = (in_rd != '0) && in_we && busy[in_rd]
                 && !(wb_en && (wb_addr == in_rd));
        hazard   = haz_rs || haz_rt || haz_rd;
        in_ready = (!out_valid || out_ready) && !hazard && started && rst_n;
        accept   = in_valid && in_ready;
    end

    // Scoreboard update: writeback clears, a new accept sets, set wins.
    always_comb begin
        busy_nxt = busy;
        if (wb_en) busy_nxt[wb_addr] = 1'b0;
        if (accept && in_we && (in_rd != '0)) busy_nxt[in_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) started <= 1'b0;
        else        started <= 1'b1;
    end

    // Register file; writes to r0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Busy bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    // Output operation register: load on accept, drop valid once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A         <= '0;
            B         <= '0;
            opcode    <= '0;
            out_rd    <= '0;
            out_we    <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            A         <= rs_val;
            B         <= b_val;
            opcode    <= in_opcode;
            out_rd    <= in_rd;
            out_we    <= in_we;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ula_operand_issue.sv
// Scoreboard bench for ula_operand_issue: the driver pushes the hand-computed
// operation for every accepted instruction, the monitor pops on each consumed
// output and compares.
module tb_ula_operand_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic        in_we, in_use_imm;
    logic [15:0] in_imm;
    logic [31:0] A, B;
    logic [4:0]  opcode, out_rd;
    logic        out_we, out_valid, out_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    ula_operand_issue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_we(in_we),
        .in_use_imm(in_use_imm), .in_imm(in_imm),
        .A(A), .B(B), .opcode(opcode), .out_rd(out_rd), .out_we(out_we),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every consumed output operation must match the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got A=%h B=%h op=%h with empty queue", A, B, opcode);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({A, B, opcode, out_rd, out_we} !== e) begin
                    errors++;
                    $display("FAIL sb_op: got A=%h B=%h op=%h rd=%h we=%b expected A=%h B=%h op=%h rd=%h we=%b",
                             A, B, opcode, out_rd, out_we, e.a, e.b, e.op, e.rd, e.we);
                end
            end
        end
    end

    // All tasks start and end one time unit after a rising edge.
    task automatic set_in(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic we, input logic ui,
                          input logic [15:0] imm);
        in_valid = 1'b1; in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_we = we; in_use_imm = ui; in_imm = imm;
    endtask

    task automatic do_wb(input logic [4:0] addr, input logic [31:0] data);
        wb_en = 1'b1; wb_addr = addr; wb_data = data;
        @(posedge clk); #1;
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic we, input logic ui,
                         input logic [15:0] imm, input logic [31:0] ea,
                         input logic [31:0] eb, input bit must_ready);
        int n;
        bit ok;
        exp_t e;
        set_in(op, rs, rt, rd, we, ui, imm);
        n = 0;
        ok = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (must_ready && n == 0) chk("ready_first_cycle", {31'd0, in_ready}, 32'd1);
            if (in_ready) begin
                ok = 1;
                e = '{a: ea, b: eb, op: op, rd: rd, we: we};
                sb.push_back(e);
            end else begin
                n++;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            errors++;
            $display("FAIL issue_timeout: got in_ready=0 for 20 cycles expected 1");
        end
        in_valid = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; in_valid = 0; in_opcode = 0; in_rs = 0; in_rt = 0; in_rd = 0;
        in_we = 0; in_use_imm = 0; in_imm = 0; out_ready = 1; wb_en = 0;
        wb_addr = 0; wb_data = 0;

        // 1: reset behaviour
        repeat (2) @(posedge clk);
        #1; chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_A", A, 32'd0);
        rst_n = 1'b1;
        #1; chk("ready_before_first_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        do_wb(5'd1, 32'd5);
        out_ready = 1'b0;
        issue(5'd1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 16'd0, 32'd5, 32'd0, 1'b1);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #3; rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_A", A, 32'd0);
        chk("midrst_B", B, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i < 32; i++)
            issue(5'(i), 5'(i), 5'(i), 5'(i), 1'b0, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1);

        // 2: register operands
        do_wb(5'd1, 32'd5);
        do_wb(5'd2, 32'd7);
        issue(5'd0, 5'd1, 5'd2, 5'd4, 1'b0, 1'b0, 16'd0, 32'd5, 32'd7, 1'b1);
        @(negedge clk);
        chk("t2_A", A, 32'd5);
        chk("t2_B", B, 32'd7);
        @(posedge clk); #1;

        // 3: sign-extended immediate
        issue(5'd2, 5'd1, 5'd9, 5'd5, 1'b0, 1'b1, 16'hFFFE, 32'd5, 32'hFFFFFFFE, 1'b1);

        // 4: RAW stall released by same-cycle writeback bypass
        issue(5'd3, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 16'd0, 32'd5, 32'd7, 1'b1);
        set_in(5'd4, 5'd3, 5'd2, 5'd6, 1'b0, 1'b0, 16'd0);
        repeat (3) begin
            @(negedge clk);
            chk("raw_stall_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd9;
        @(negedge clk);
        chk("raw_bypass_ready", {31'd0, in_ready}, 32'd1);
        if (in_ready) begin
            e = '{a: 32'd9, b: 32'd7, op: 5'd4, rd: 5'd6, we: 1'b0};
            sb.push_back(e);
        end
        @(posedge clk); #1;
        wb_en = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("raw_bypass_A", A, 32'd9);
        @(posedge clk); #1;

        // 5: backpressure
        out_ready = 1'b0;
        issue(5'h0A, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0, 16'd0, 32'd5, 32'd7, 1'b1);
        set_in(5'h0B, 5'd2, 5'd1, 5'd8, 1'b0, 1'b0, 16'd0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_A", A, 32'd5);
            chk("bp_B", B, 32'd7);
            chk("bp_opcode", {27'd0, opcode}, 32'h0A);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        if (in_ready) begin
            e = '{a: 32'd7, b: 32'd5, op: 5'h0B, rd: 5'd8, we: 1'b0};
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        // 6: r0 is hardwired zero and never busy
        do_wb(5'd0, 32'hDEAD);
        issue(5'd6, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 16'd0, 32'd0, 32'd0, 1'b1);
        issue(5'd7, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 16'd0, 32'd0, 32'd5, 1'b1);

        // drain, valid must drop with no new accept
        repeat (3) @(posedge clk);
        #1;
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
